// File: rtl/i2s_encoder.sv
// i2s_encoder: 16-bit stereo I2S transmitter with a one-pair holding register.
// Build option: define I2S_UNDERRUN_MUTE_EN to send a silent frame on underrun
// instead of repeating the last pair.
module i2s_encoder #(
    parameter int DIV = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] left,
    input  logic [15:0] right,
    input  logic        valid,
    output logic        ready,
    output logic        underrun,
    output logic [2:0]  i2s
);
    logic [7:0]  cnt;
    logic [5:0]  b, nb;
    logic        sck, ws, sd, tick, fall, fs, full;
    logic [15:0] hold_l, hold_r, act_l, act_r, nl, nr;

    // SCK edge detection, next bit index and the words the next bit is taken from
    always_comb begin
        tick = cnt == 8'(DIV - 1);
        fall = tick && sck;
        fs   = fall && b == 6'd63;
        nb   = b + 6'd1;
`ifdef I2S_UNDERRUN_MUTE_EN
        nl   = fs ? (full ? hold_l : 16'd0) : act_l;
        nr   = fs ? (full ? hold_r : 16'd0) : act_r;
`else
        nl   = (fs && full) ? hold_l : act_l;
        nr   = (fs && full) ? hold_r : act_r;
`endif
    end

    // clock divider producing SCK and the bit index advanced on SCK falling edges
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            sck <= 1'b0;
            b   <= 6'd63;
        end else begin
            cnt <= tick ? 8'd0 : cnt + 8'd1;
            if (tick)
                sck <= ~sck;
            if (fall)
                b <= nb;
        end
    end

    // WS/SD launched on SCK falling edges; holding register handshake and frame-start swap
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ws       <= 1'b0;
            sd       <= 1'b0;
            underrun <= 1'b0;
            full     <= 1'b0;
            hold_l   <= '0;
            hold_r   <= '0;
            act_l    <= '0;
            act_r    <= '0;
        end else begin
            underrun <= fs && !full;
            if (fall) begin
                ws    <= nb >= 6'd31 && nb <= 6'd62;
                sd    <= nb[4] ? 1'b0 : (nb[5] ? nr[~nb[3:0]] : nl[~nb[3:0]]);
                act_l <= nl;
                act_r <= nr;
            end
            if (fs && full)
                full <= 1'b0;
            else if (valid && !full) begin
                full   <= 1'b1;
                hold_l <= left;
                hold_r <= right;
            end
        end
    end

    assign ready = ~full;
    assign i2s   = {sd, ws, sck};
endmodule

// File: tb/tb_i2s_encoder.sv
// tb_i2s_encoder: table-driven, hand-sequenced and random checks of i2s_encoder against a time-based reference and an I2S decoder.
module tb_i2s_encoder;
    localparam int DIV = 4;
    localparam int HP  = 2 * DIV;
    localparam int FR  = 128 * DIV;

    logic        clock = 0, reset = 1, valid = 0;
    logic [15:0] left = 0, right = 0;
    logic        ready, underrun;
    logic [2:0]  i2s;

    int vectors = 0, miscompares = 0;

    int          t;
    bit          m_full, fs_e, ur_e;
    logic [15:0] m_al, m_ar, m_hl, m_hr;

    logic [31:0] dec_q[$];
    logic [15:0] dec_l, dec_sh;
    logic        dec_ws, dec_ch, prev_sck;
    int          dec_n;

    typedef struct {
        logic [15:0] l, r;
        logic [15:0] el, er;
        logic        rdy_after;
    } vec_t;
    vec_t tab[4];

    i2s_encoder #(.DIV(DIV)) dut (
        .clock(clock), .reset(reset), .left(left), .right(right),
        .valid(valid), .ready(ready), .underrun(underrun), .i2s(i2s)
    );

    always #5 clock = ~clock;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting, got none expected event at %0t", name, $time);
    endtask

    // reference: sample clock count since reset release, bit index and word set from spec arithmetic
    always begin
        @(posedge clock);
        if (reset) begin
            t = 0; m_full = 0; m_al = 0; m_ar = 0; m_hl = 0; m_hr = 0; ur_e = 0;
            dec_ws = 1; dec_ch = 0; dec_n = 16; prev_sck = 0; dec_l = 0; dec_sh = 0;
            #1;
            check("rst_i2s", {29'd0, i2s}, 32'd0);
            check("rst_ready", {31'd0, ready}, 32'd1);
            check("rst_underrun", {31'd0, underrun}, 32'd0);
        end else begin
            int   bb;
            logic e_sck, e_ws, e_sd;
            t++;
            fs_e = t >= HP && (t - HP) % FR == 0;
            ur_e = fs_e && !m_full;
            if (fs_e && m_full) begin
                m_al = m_hl; m_ar = m_hr; m_full = 0;
            end else begin
`ifdef I2S_UNDERRUN_MUTE_EN
                if (ur_e) begin m_al = 0; m_ar = 0; end
`endif
                if (valid && !m_full) begin m_hl = left; m_hr = right; m_full = 1; end
            end
            bb    = ((t / HP) + 63) % 64;
            e_sck = ((t / DIV) % 2) == 1;
            e_ws  = bb >= 31 && bb <= 62;
            if (bb < 16)
                e_sd = m_al[4'(15 - bb)];
            else if (bb >= 32 && bb < 48)
                e_sd = m_ar[4'(47 - bb)];
            else
                e_sd = 1'b0;
            #1;
            check("i2s", {29'd0, i2s}, {29'd0, e_sd, e_ws, e_sck});
            check("ready", {31'd0, ready}, {31'd0, !m_full});
            check("underrun", {31'd0, underrun}, {31'd0, ur_e});
            if (i2s[0] && !prev_sck) begin
                if (dec_n < 16) begin
                    dec_sh = {dec_sh[14:0], i2s[2]};
                    dec_n++;
                    if (dec_n == 16) begin
                        if (dec_ch) dec_q.push_back({dec_l, dec_sh});
                        else dec_l = dec_sh;
                    end
                end
                if (i2s[1] != dec_ws) begin
                    dec_ws = i2s[1]; dec_ch = i2s[1]; dec_n = 0;
                end
            end
            prev_sck = i2s[0];
        end
    end

    task automatic wait_b(int target);
        bit ok = 0;
        for (int i = 0; i < 4 * FR && !ok; i++) begin
            @(negedge clock);
            ok = t > 0 && t % HP == 0 && ((t / HP) + 63) % 64 == target;
        end
        if (!ok) timeout("wait_b");
    endtask

    task automatic wait_pre_fs();
        bit ok = 0;
        for (int i = 0; i < 4 * FR && !ok; i++) begin
            @(negedge clock);
            ok = t % HP == HP - 1 && ((t / HP) + 63) % 64 == 63;
        end
        if (!ok) timeout("wait_pre_fs");
    endtask

    task automatic wait_dec(int n, output bit ok);
        ok = dec_q.size() >= n;
        for (int i = 0; i < 4 * FR && !ok; i++) begin
            @(negedge clock);
            ok = dec_q.size() >= n;
        end
        if (!ok) timeout("wait_dec");
    endtask

    task automatic post_reset_checks();
        repeat (3) @(negedge clock);
        check("sck_low_3", {31'd0, i2s[0]}, 32'd0);
        @(negedge clock);
        check("sck_rise_4", {31'd0, i2s[0]}, 32'd1);
        repeat (3) @(negedge clock);
        check("no_frame_7", {31'd0, underrun}, 32'd0);
        @(negedge clock);
        check("frame0_ur_8", {31'd0, underrun}, 32'd1);
        check("frame0_sck_8", {31'd0, i2s[0]}, 32'd0);
    endtask

    initial begin
        bit          ok;
        logic [15:0] ul, ur;
        tab[0] = '{16'hA5C3, 16'h0F0F, 16'hA5C3, 16'h0F0F, 1'b0};
        tab[1] = '{16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 1'b0};
        tab[2] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001, 1'b0};
        tab[3] = '{16'h1234, 16'hFEDC, 16'h1234, 16'hFEDC, 1'b0};

        repeat (3) @(negedge clock);
        reset = 0;
        post_reset_checks();

        for (int i = 0; i < 4; i++) begin
            wait_b(1);
            check("tab_ready_before", {31'd0, ready}, 32'd1);
            dec_q.delete();
            left = tab[i].l; right = tab[i].r; valid = 1;
            @(negedge clock);
            valid = 0;
            check("tab_ready_after", {31'd0, ready}, {31'd0, tab[i].rdy_after});
            wait_dec(2, ok);
            if (ok) begin
                check("tab_left", {16'd0, dec_q[1][31:16]}, {16'd0, tab[i].el});
                check("tab_right", {16'd0, dec_q[1][15:0]}, {16'd0, tab[i].er});
            end
        end

`ifdef I2S_UNDERRUN_MUTE_EN
        ul = 16'h0; ur = 16'h0;
`else
        ul = tab[3].el; ur = tab[3].er;
`endif
        wait_b(1);
        dec_q.delete();
        wait_dec(2, ok);
        if (ok) begin
            check("underrun_frame_a", dec_q[0], {ul, ur});
            check("underrun_frame_b", dec_q[1], {ul, ur});
        end

        wait_b(1);
        dec_q.delete();
        left = 16'h1111; right = 16'h2222; valid = 1;
        @(negedge clock);
        check("bp_ready_drop", {31'd0, ready}, 32'd0);
        left = 16'h3333; right = 16'h4444;
        ok = 0;
        for (int i = 0; i < 2 * FR && !ok; i++) begin
            @(negedge clock);
            ok = ready;
        end
        if (!ok) timeout("bp_ready_return");
        check("bp_ready_at_b0", ((t / HP) + 63) % 64, 32'd0);
        @(negedge clock);
        valid = 0;
        check("bp_second_taken", {31'd0, ready}, 32'd0);
        wait_dec(3, ok);
        if (ok) begin
            check("bp_pair1", dec_q[1], 32'h1111_2222);
            check("bp_pair2", dec_q[2], 32'h3333_4444);
        end

`ifdef I2S_UNDERRUN_MUTE_EN
        ul = 16'h0; ur = 16'h0;
`else
        ul = 16'h3333; ur = 16'h4444;
`endif
        wait_b(1);
        wait_pre_fs();
        dec_q.delete();
        left = 16'hBEEF; right = 16'hCAFE; valid = 1;
        @(negedge clock);
        valid = 0;
        check("coinc_underrun", {31'd0, underrun}, 32'd1);
        check("coinc_ready", {31'd0, ready}, 32'd0);
        wait_dec(2, ok);
        if (ok) begin
            check("coinc_ur_frame", dec_q[0], {ul, ur});
            check("coinc_next_frame", dec_q[1], 32'hBEEF_CAFE);
        end

        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            valid = $urandom_range(0, 99) < 2;
            left  = 16'($urandom);
            right = 16'($urandom);
        end
        valid = 0;

        wait_b(5);
        left = 16'h5A5A; right = 16'hA5A5; valid = 1;
        @(negedge clock);
        valid = 0;
        #2;
        reset = 1;
        #1;
        check("async_rst_i2s", {29'd0, i2s}, 32'd0);
        check("async_rst_ready", {31'd0, ready}, 32'd1);
        check("async_rst_underrun", {31'd0, underrun}, 32'd0);
        repeat (3) @(negedge clock);
        reset = 0;
        post_reset_checks();
        dec_q.delete();
        wait_dec(1, ok);
        if (ok) check("post_rst_frame", dec_q[0], 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/i2s_encoder.md
I2S_ENCODER -- requirements
Module: i2s_encoder

Interface
REQ-001 SHALL have parameter DIV, default 4, giving the number of clock cycles per SCK half-period (legal range 2..255).
REQ-002 SHALL have port clock, input, 1 bit: the single system clock; every register is clocked on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port left, input, 16 bits: left-channel sample, two's complement.
REQ-005 SHALL have port right, input, 16 bits: right-channel sample, two's complement.
REQ-006 SHALL have port valid, input, 1 bit: the left/right pair is offered this cycle.
REQ-007 SHALL have port ready, output, 1 bit: the holding register is empty and can accept a pair.
REQ-008 SHALL have port underrun, output, 1 bit: one-cycle pulse marking a frame start with no pair held.
REQ-009 SHALL have port i2s, output, 3 bits: bit 0 = SCK, bit 1 = WS, bit 2 = SD.

Function
REQ-010 SHALL divide the clock with a counter cnt running 0..DIV-1 and toggle SCK on the cycle when cnt = DIV-1, giving an SCK period of 2*DIV clocks.
REQ-011 SHALL keep a bit index b in the range 0..63 and advance it modulo 64 only on the cycle where SCK goes from 1 to 0 (falling edge).
REQ-012 SHALL change WS and SD only on SCK falling edges, so both are stable at every SCK rising edge.
REQ-013 SHALL use a frame of 64 SCK periods: a left slot (b 0..31) followed by a right slot (b 32..63), each slot 32 bits wide.
REQ-014 SHALL drive SD with the active word's bits in each slot as follows:
- b 0..15: left word, MSB first (bit 15-b).
- b 16..31: 0.
- b 32..47: right word, MSB first (bit 47-b).
- b 48..63: 0.
REQ-015 SHALL drive WS = 1 for b 31..62 and WS = 0 for b 63 and b 0..30, so WS leads each slot's MSB by one SCK (standard I2S: WS 0 = left, WS 1 = right).
REQ-016 SHALL load the holding register from left and right when valid and ready are both 1 on a clock edge, and SHALL drop ready on the next cycle.
REQ-017 SHALL, at each frame start (the falling edge where b wraps from 63 to 0), handle the active words as follows:
- Holding register full: copy it into the active left/right words in that cycle, so left[15] appears on SD at b = 0.
- Holding register full: raise ready again on the following cycle.
REQ-018 SHALL, at a frame start with the holding register empty, pulse underrun high for exactly one clock, and update the active words as set by REQ-026/REQ-027.
REQ-019 SHALL, when valid and ready coincide with a frame start that finds the holding register empty:
- Report that frame as an underrun.
- Store the offered pair in the holding register for the next frame.
REQ-020 SHALL never overwrite the holding register while ready = 0; a valid held high waits until ready returns.
REQ-021 SHALL give a sample rate of clock / (128*DIV); DIV = 4 gives a 512-clock frame.

Reset
REQ-022 SHALL, while reset = 1, hold i2s = 3'b000, cnt = 0, b = 63, the active words at 0, the holding register empty, ready = 1 and underrun = 0.
REQ-023 SHALL, when reset is asserted mid-frame, force the REQ-022 values immediately (asynchronously) and discard any held or partly sent pair.
REQ-024 SHALL, after reset is released:
- Produce the first SCK rising edge DIV clocks later.
- Make the first falling edge (2*DIV clocks) the start of frame b = 0.

Configuration
REQ-025 SHALL provide the macro I2S_UNDERRUN_MUTE_EN to select underrun behaviour.
REQ-026 SHALL, with I2S_UNDERRUN_MUTE_EN defined, clear both active words to 0 on underrun, giving a silent frame.
REQ-027 SHALL, with I2S_UNDERRUN_MUTE_EN not defined, keep the active words unchanged on underrun, repeating the last pair; the underrun pulse is generated either way.

Verification (DIV = 4)
REQ-028 SHALL check reset: assert reset mid-frame -> i2s = 000 and ready = 1 in the same cycle; release -> SCK rises 4 clocks later and b = 0 at clock 8.
REQ-029 SHALL check a loopback through the I2S decoder: one-cycle valid with left = 16'hA5C3, right = 16'h0F0F before a frame start -> decoder outputs left = A5C3 and right = 0F0F; ready = 0 until the frame start, then 1.
REQ-030 SHALL check timing against a bit-accurate model: WS toggles only on SCK falling edges, one SCK before each MSB; SD = 0 during b 16..31 and b 48..63.
REQ-031 SHALL check underrun: no valid for one frame -> underrun high for 1 clock at b = 0; SD all zero (macro defined) or the previous pair repeated (macro undefined).
REQ-032 SHALL check back-pressure: valid held high with pair 1111/2222, then 3333/4444 -> the second pair is accepted only after the next frame start; both pairs are transmitted in order with no loss.
REQ-033 SHALL check the coincident case: valid arrives in the same cycle as a frame start with the holding register empty -> underrun pulses, and that pair is sent in the following frame.
